// File: rtl/register_file.sv
// register_file: 32x32 register file, two combinational read ports, one write port with same-cycle bypass
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   input  logic [ADDR_WIDTH-1:0] WriteRegister,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  RegWrite,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2
);
   localparam int Depth = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] regs [Depth];
   logic writeEn;
   assign writeEn = Reset_n && RegWrite && (WriteRegister != '0);
   // async clear of all entries; entry 0 is never written so it stays zero
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) for (int i = 0; i < Depth; i++) regs[i] <= '0;
      else if (writeEn) regs[WriteRegister] <= WriteData;
   // zero index and reset force 0; a pending write to the same index is forwarded
   always_comb begin
      ReadData1 = (!Reset_n || ReadRegister1 == '0) ? '0 :
                  (writeEn && WriteRegister == ReadRegister1) ? WriteData : regs[ReadRegister1];
      ReadData2 = (!Reset_n || ReadRegister2 == '0) ? '0 :
                  (writeEn && WriteRegister == ReadRegister2) ? WriteData : regs[ReadRegister2];
   end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed table-driven checks of register_file
module tb_register_file;
   logic Clk, Reset_n, RegWrite;
   logic [4:0] ReadRegister1, ReadRegister2, WriteRegister;
   logic [31:0] WriteData, ReadData1, ReadData2;
   int total = 0, bad = 0;

   typedef struct {
      logic we;
      logic [4:0] wa;
      logic [31:0] wd;
      logic [4:0] r1, r2;
      logic [31:0] e1, e2;
   } vec_t;
   vec_t vecs[12];

   register_file dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
      .ReadData1(ReadData1), .ReadData2(ReadData2)
   );

   initial begin
      Clk = 0;
      forever #50 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      RegWrite = we; WriteRegister = wa; WriteData = wd;
      ReadRegister1 = r1; ReadRegister2 = r2;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd16, 32'hDEADDAD5, 5'd16, 5'd0,  32'hDEADDAD5, 32'h0};
      vecs[1]  = '{1'b0, 5'd16, 32'h0,        5'd16, 5'd16, 32'hDEADDAD5, 32'hDEADDAD5};
      vecs[2]  = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd16, 32'hDEADBEEF, 32'hDEADDAD5};
      vecs[3]  = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'hDEADBEEF, 32'h0};
      vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
      vecs[6]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
      vecs[7]  = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd16, 32'h0,        32'hDEADDAD5};
      vecs[8]  = '{1'b0, 5'd5,  32'h12345678, 5'd5,  5'd0,  32'h0,        32'h0};
      vecs[9]  = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd5,  32'h12345678, 32'h12345678};
      vecs[10] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd31, 32'h12345678, 32'hDEADBEEF};
      vecs[11] = '{1'b1, 5'd7,  32'hAAAA5555, 5'd5,  5'd7,  32'h12345678, 32'hAAAA5555};

      Reset_n = 0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1;
      // reset state, read without any write
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 0, 5'(i), 5'(31 - i));
         #1 chk($sformatf("init_r1_%0d", i), ReadData1, 32'h0);
         chk($sformatf("init_r2_%0d", 31 - i), ReadData2, 32'h0);
      end

      // directed table: check before the edge, write lands on the edge
      foreach (vecs[k]) begin
         @(negedge Clk);
         drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].r1, vecs[k].r2);
         #1 chk($sformatf("vec%0d_rd1", k), ReadData1, vecs[k].e1);
         chk($sformatf("vec%0d_rd2", k), ReadData2, vecs[k].e2);
      end

      // sweep writes, each visible through the bypass in its own cycle
      for (int i = 1; i < 32; i++) begin
         @(negedge Clk);
         drive(1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'd0);
         #1 chk($sformatf("sweep_byp_%0d", i), ReadData1, 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         @(negedge Clk);
         drive(0, 0, 0, 5'(i), 5'(31 - i));
         #1 chk($sformatf("sweep_rd1_%0d", i), ReadData1, 32'(i) * 32'h01010101);
         chk($sformatf("sweep_rd2_%0d", 31 - i), ReadData2, 32'(31 - i) * 32'h01010101);
      end

      // mid-cycle async reset with a pending write: everything reads 0, no bypass
      @(negedge Clk);
      drive(1, 5'd3, 32'hFFFF0000, 5'd3, 5'd3);
      #5 Reset_n = 0;
      #1 chk("rst_bypass_off", ReadData1, 32'h0);
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         #1 chk($sformatf("rst_r1_%0d", i), ReadData1, 32'h0);
         chk($sformatf("rst_r2_%0d", 31 - i), ReadData2, 32'h0);
      end
      @(negedge Clk);
      drive(0, 5'd3, 32'hFFFF0000, 5'd3, 5'd31);
      Reset_n = 1;
      #1 chk("post_rst_reg3", ReadData1, 32'h0);
      chk("post_rst_reg31", ReadData2, 32'h0);
      @(negedge Clk);
      #1 chk("post_rst_reg3_edge", ReadData1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
